// File: rtl/gauss_window_gen_if.sv
// rtl/gauss_window_gen_if.sv - pixel stream in, 3x3 window and kernel select out
interface gauss_window_gen_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] line0_data0, line0_data1, line0_data2;
    logic [DATA_WIDTH-1:0] line1_data0, line1_data1, line1_data2;
    logic [DATA_WIDTH-1:0] line2_data0, line2_data1, line2_data2;
    logic [3:0]            corner_type;

    modport master (
        output in_valid, in_data,
        input  in_ready, out_valid, corner_type,
        input  line0_data0, line0_data1, line0_data2,
        input  line1_data0, line1_data1, line1_data2,
        input  line2_data0, line2_data1, line2_data2
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, out_valid, corner_type,
        output line0_data0, line0_data1, line0_data2,
        output line1_data0, line1_data1, line1_data2,
        output line2_data0, line2_data1, line2_data2
    );
endinterface

// File: rtl/gauss_window_gen.sv
// rtl/gauss_window_gen.sv - 3x3 neighbourhood generator with edge masking and flush
module gauss_window_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 64
) (
    input logic               clk,
    input logic               rst_n,
    gauss_window_gen_if.slave bus
);
    // chain[0] is the newest pixel (centre + IMG_W + 1), so tap (r,k) sits at chain[r*IMG_W+k].
    localparam int DEPTH = 2 * IMG_W + 3;
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_t;

    state_t                state;
    logic [XW-1:0]         in_x, out_x;
    logic [YW-1:0]         in_y, out_y;
    logic [DATA_WIDTH-1:0] chain     [DEPTH];
    logic [DATA_WIDTH-1:0] chain_nxt [DEPTH];
    logic [DATA_WIDTH-1:0] win_q     [3][3];
    logic [DATA_WIDTH-1:0] win_d     [3][3];
    logic                  in_ready_q, out_valid_q;
    logic [3:0]            corner_q, corner_d;
    logic                  accept, flushing, in_last, release_first, out_last, emit;

    assign flushing      = (state == S_FLUSH);
    assign accept        = bus.in_valid && in_ready_q;
    assign in_last       = (in_x == X_LAST) && (in_y == Y_LAST);
    assign release_first = (in_x == XW'(1)) && (in_y == YW'(1));
    assign out_last      = (out_x == X_LAST) && (out_y == Y_LAST);
    assign emit          = flushing ||
                           (accept && (state == S_RUN || (state == S_FILL && release_first)));

    always_comb begin
        chain_nxt[0] = flushing ? '0 : bus.in_data;
        for (int i = 1; i < DEPTH; i++) begin
            chain_nxt[i] = chain[i-1];
        end
    end

    // Masking relies only on the centre position, so stale line contents never leak out.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
                win_d[r][k] = '0;
                if (!(k == 0 && out_x == X_LAST) && !(k == 2 && out_x == '0) &&
                    !(r == 0 && out_y == Y_LAST) && !(r == 2 && out_y == '0)) begin
                    win_d[r][k] = chain_nxt[r*IMG_W+k];
                end
            end
        end
    end

    always_comb begin
        corner_d = 4'd8;
        if      (out_y == '0     && out_x == '0)     corner_d = 4'd1;
        else if (out_y == '0     && out_x == X_LAST) corner_d = 4'd2;
        else if (out_y == Y_LAST && out_x == '0)     corner_d = 4'd5;
        else if (out_y == Y_LAST && out_x == X_LAST) corner_d = 4'd6;
        else if (out_x == '0)                        corner_d = 4'd3;
        else if (out_x == X_LAST)                    corner_d = 4'd4;
        else if (out_y == '0 || out_y == Y_LAST)     corner_d = 4'd7;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            in_x        <= '0;
            in_y        <= '0;
            out_x       <= '0;
            out_y       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            corner_q    <= '0;
            for (int i = 0; i < DEPTH; i++) chain[i] <= '0;
            for (int r = 0; r < 3; r++)
                for (int k = 0; k < 3; k++) win_q[r][k] <= '0;
        end else begin
            if (accept || flushing) chain <= chain_nxt;

            out_valid_q <= emit;
            corner_q    <= emit ? corner_d : 4'd0;
            for (int r = 0; r < 3; r++)
                for (int k = 0; k < 3; k++) win_q[r][k] <= emit ? win_d[r][k] : '0;

            if (accept) begin
                if (in_x == X_LAST) begin
                    in_x <= '0;
                    in_y <= (in_y == Y_LAST) ? '0 : in_y + 1'b1;
                end else begin
                    in_x <= in_x + 1'b1;
                end
            end

            if (emit) begin
                if (out_x == X_LAST) begin
                    out_x <= '0;
                    out_y <= (out_y == Y_LAST) ? '0 : out_y + 1'b1;
                end else begin
                    out_x <= out_x + 1'b1;
                end
            end

            case (state)
                S_IDLE:  if (accept) state <= S_FILL;
                S_FILL:  if (accept && release_first) state <= S_RUN;
                S_RUN: begin
                    if (accept && in_last) begin
                        state      <= S_FLUSH;
                        in_ready_q <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (out_last) begin
                        state      <= S_IDLE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.corner_type = corner_q;
    assign bus.line0_data0 = win_q[0][0];
    assign bus.line0_data1 = win_q[0][1];
    assign bus.line0_data2 = win_q[0][2];
    assign bus.line1_data0 = win_q[1][0];
    assign bus.line1_data1 = win_q[1][1];
    assign bus.line1_data2 = win_q[1][2];
    assign bus.line2_data0 = win_q[2][0];
    assign bus.line2_data1 = win_q[2][1];
    assign bus.line2_data2 = win_q[2][2];
endmodule

// File: doc/gauss_window_gen.md
# gauss_window_gen

- Upstream stage of the 3x3 Gaussian computing block.
- Accepts a raster-order pixel stream and buffers two image lines in internal line memories. Each cycle it presents a registered 3x3 neighbourhood around one centre pixel, plus the `corner_type` code that selects the edge-corrected kernel downstream.
- Taps that fall outside the image are forced to 0.
- After the last input pixel of a frame, the block flushes the remaining centres internally.

## Interface
- `DATA_WIDTH`, 8 — pixel width.
- `IMG_W`, 64 — pixels per line, minimum 3.
- `IMG_H`, 64 — lines per frame, minimum 3.
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `in_valid` in 1 — input pixel present.
- `in_data` in DATA_WIDTH — input pixel.
- `in_ready` out 1 — pixel accepted when `in_valid & in_ready`.
- `out_valid` out 1 — window/type valid this cycle.
- `lineR_dataK` out DATA_WIDTH, for R,K ∈ {0,1,2}, nine ports. Tap (R,K) is the pixel at (xc+1−K, yc+1−R) relative to centre (xc,yc):
  - `line1_data1` is the centre.
  - Row 0 is y+1; column 0 is x+1.
- `corner_type` out 4 — kernel select code.

## Operation
- **Input counters.** in_x/in_y track the next input pixel. Linear index p = in_y*IMG_W+in_x.
- **Output counters.** out_x/out_y track the next centre.
- **Centre release.** Accepting pixel p releases centre c = p−(IMG_W+1) when p ≥ IMG_W+1.
- **Storage.** Two IMG_W-deep line memories (or shift chains) plus a 3x3 register window.
- **FSM.**
  - IDLE: no frame in progress, in_ready=1. First accept → FILL.
  - FILL: accept pixels. When p = IMG_W+1 is accepted, emit the first centre and go → RUN.
  - RUN: one output per accepted pixel. When the accepted pixel is the last one (p = IMG_W*IMG_H−1) → FLUSH.
  - FLUSH: in_ready=0. Emit one centre per cycle using zero virtual input, IMG_W+1 outputs in total. After the centre (IMG_W−1, IMG_H−1) is emitted → IDLE.
- **Masking.** Any tap with x<0, x≥IMG_W, y<0 or y≥IMG_H outputs 0. Stale line-memory contents from the previous frame must never appear.
- **corner_type** for centre (x,y), evaluated in this priority order:
  - y=0, x=0 → 1
  - y=0, x=W−1 → 2
  - y=H−1, x=0 → 5
  - y=H−1, x=W−1 → 6
  - x=0 → 3
  - x=W−1 → 4
  - y=0 or y=H−1 → 7
  - otherwise → 8
  - When out_valid=0, corner_type = 0.
- **Input gaps.** in_valid gaps in FILL/RUN stall all state; no output is produced on those cycles.
- **in_valid in FLUSH.** Ignored; in_ready=0.
- **Frame boundaries.** Frames are back-to-back: a pixel arriving after FLUSH→IDLE starts a new frame at (0,0). No frame marker is used.

## Timing
- **Reset.** Asynchronous on rst_n low:
  - state=IDLE, all counters 0;
  - out_valid=0, all nine taps 0, corner_type=0, in_ready=1.
- **Reset mid-frame.** The partial frame is discarded; the next accepted pixel is (0,0).
- **Output registration.** All outputs are registered. An accept at edge N produces out_valid, window and type at edge N+1, held for exactly one cycle.
- **Latency.** Pixel p → its centre appears 1 cycle after pixel p+IMG_W+1 is accepted. In FLUSH this becomes one centre per cycle.
- **Throughput.** 1 pixel/cycle sustained.
- **Frame duration.** A frame of IMG_W*IMG_H pixels yields exactly IMG_W*IMG_H outputs.
- **FLUSH length.** Exactly IMG_W+1 cycles, with in_ready low throughout.
- **FLUSH → IDLE edge.** in_ready returns high the cycle after the final output.
- **No backpressure.** The downstream stage is combinational and consumes every out_valid.

## Test plan
All scenarios use IMG_W=4, IMG_H=3, DATA_WIDTH=8, and pixel value = linear index+1 (1..12), continuous in_valid.

1. **First output.** After accepting value 6 (p=5), the next cycle gives out_valid=1, corner_type=1, line1_data1=1, line1_data0=2, line0_data1=5, line0_data0=6, all other taps 0.
2. **Interior and edge windows.**
   - Centre (1,1): type 8; row0 = 11,10,9; row1 = 7,6,5; row2 = 3,2,1.
   - Centre (1,0): type 7, row2 all 0.
   - Centre (0,1): type 3, column 2 all 0.
3. **Flush.**
   - After value 12 is accepted: in_ready=0 for 5 cycles, emitting centres 8..12.
   - Last output: type 6, line1_data1=12, line1_data2=11, line2_data1=8, line2_data2=7, others 0.
   - in_ready returns to 1 next cycle. Total out_valid pulses = 12.
4. **Input gaps.** Random in_valid gaps (≈50%) produce the same 12 windows in the same order. No out_valid on stalled cycles, except during FLUSH, where output continues one per cycle independent of in_valid.
5. **Reset mid-frame.**
   - Assert rst_n low after value 7 is accepted: all outputs 0 immediately (asynchronous), in_ready=1.
   - Restart with a full frame: the outputs are identical to scenario 1–3 with no stale data.
6. **Back-to-back frames.** A second frame with values 101..112 starts on the cycle in_ready returns high. Its first window is type 1, centre 101, with all out-of-image taps 0.
